// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: one-entry holding registers for the ALU and the load unit, plus a busy scoreboard.
// Optional WB_FAIR_EN: an ALU anti-starvation counter forces an ALU win after three consecutive losses.
module writeback_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned RW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [RW-1:0]    alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [RW-1:0]    ld_rd,
    input  logic [XLEN-1:0]  ld_data,
    input  logic             issue_valid,
    input  logic [RW-1:0]    issue_rd,
    output logic [NREGS-1:0] busy,
    output logic             write_en,
    output logic [RW-1:0]    write_to,
    output logic [XLEN-1:0]  write_data
);

    logic             alu_full, ld_full;
    logic [RW-1:0]    alu_rd_q, ld_rd_q;
    logic [XLEN-1:0]  alu_data_q, ld_data_q;

    logic             alu_force;
    logic             alu_win, ld_win, any_win;
    logic [RW-1:0]    win_rd;
    logic [XLEN-1:0]  win_data;
    logic [NREGS-1:0] busy_next;

`ifdef WB_FAIR_EN
    logic [1:0] alu_starve;

    assign alu_force = alu_full && (alu_starve == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_starve <= '0;
        end else if (alu_win) begin
            alu_starve <= '0;
        end else if (alu_full && ld_win) begin
            alu_starve <= alu_starve + 2'd1;
        end
    end
`else
    assign alu_force = 1'b0;
`endif

    always_comb begin
        ld_win   = ld_full && !alu_force;
        alu_win  = alu_full && !ld_win;
        any_win  = ld_win || alu_win;
        win_rd   = ld_win ? ld_rd_q : alu_rd_q;
        win_data = ld_win ? ld_data_q : alu_data_q;
    end

    // Ready is gated by rst_n so no source sees a handshake while reset is held.
    always_comb begin
        alu_ready = rst_n && (!alu_full || alu_win);
        ld_ready  = rst_n && (!ld_full || ld_win);
    end

    // Clear of the drained rd first, then set, so a same-edge re-issue keeps the bit.
    always_comb begin
        busy_next = busy;
        if (any_win) begin
            busy_next[win_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full   <= 1'b0;
            alu_rd_q   <= '0;
            alu_data_q <= '0;
        end else begin
            if (alu_valid && alu_ready) begin
                alu_full   <= 1'b1;
                alu_rd_q   <= alu_rd;
                alu_data_q <= alu_data;
            end else if (alu_win) begin
                alu_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_full   <= 1'b0;
            ld_rd_q   <= '0;
            ld_data_q <= '0;
        end else begin
            if (ld_valid && ld_ready) begin
                ld_full   <= 1'b1;
                ld_rd_q   <= ld_rd;
                ld_data_q <= ld_data;
            end else if (ld_win) begin
                ld_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_to   <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_next;
            if (any_win) begin
                write_en   <= (win_rd != '0);
                write_to   <= win_rd;
                write_data <= win_data;
            end else begin
                write_en <= 1'b0;
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the register-file write port: drives write_en / write_to / write_data into the register bank.
- Collects results from two execution sources, the ALU and the load unit, each through a valid/ready handshake, and buffers one result per source.
- Arbitrates one write per cycle between them.
- Keeps a busy scoreboard of destination registers with outstanding writes, which issue logic uses for hazard stalls.

Parameters:
- XLEN, 32, data width; matches DataType from cornigera_pkg.
- NREGS, 32, number of architectural registers; width of busy.
- RW, 5, register index width; must satisfy 2**RW == NREGS.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU holding register can accept.
- alu_rd  input  RW  ALU destination register.
- alu_data  input  XLEN  ALU result.
- ld_valid  input  1  load result valid.
- ld_ready  output  1  load holding register can accept.
- ld_rd  input  RW  load destination register.
- ld_data  input  XLEN  load data.
- issue_valid  input  1  an instruction with a destination was issued this cycle.
- issue_rd  input  RW  destination of the issued instruction.
- busy  output  NREGS  scoreboard; bit r = write to r pending.
- write_en  output  1  register-file write enable.
- write_to  output  RW  register-file write index.
- write_data  output  XLEN  register-file write data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both holding registers empty; busy = 0.
  - write_en = 0, write_to = 0, write_data = 0.
  - alu_ready = ld_ready = 0 while rst_n is low.
- Holding registers, one per source, one entry each:
  - Accept happens on the rising edge where valid && ready.
  - ready = holding register empty, OR it is full and wins arbitration in the current cycle (drain-and-refill, no bubble).
  - Data and rd must be held stable by the source while valid && !ready.
- Arbitration, combinational from the holding-register state each cycle:
  - Load holding register, if full, wins.
  - Otherwise the ALU holding register, if full, wins.
  - The winner is drained at the next edge.
- Write port, registered:
  - At the edge that drains the winner: write_en <= (winner_rd != 0), write_to <= winner_rd, write_data <= winner_data.
  - With no winner: write_en <= 0; write_to / write_data hold their previous values.
- Latency:
  - Handshake at edge k.
  - write_en is high during the cycle after edge k+1, provided the entry wins at k+1.
  - Minimum 2 edges from handshake to the register-file write edge.
- Throughput: 1 write per cycle total; a lone source sustains 1 per cycle.
- rd == 0: the entry is accepted and drained normally and consumes the arbitration slot, but write_en stays 0.
- Scoreboard:
  - Set: busy[r] <= 1 on an edge with issue_valid && issue_rd == r && r != 0.
  - Clear: busy[r] <= 0 on the edge that drains a winner with rd == r.
  - Set and clear of the same r on the same edge: set wins, because a newer producer is outstanding.
  - busy[0] is constant 0.
- Both sources targeting the same rd in the same cycle: load is written first, ALU one cycle later. The issue logic guarantees program order through the scoreboard; this block does not reorder.
- Reset asserted mid-operation: buffered entries are discarded and no write is emitted after rst_n rises until a new handshake.

Optional Feature:
- Macro: WB_FAIR_EN.
- Defined:
  - A 2-bit counter alu_starve increments on each cycle the ALU holding register is full and loses arbitration.
  - When alu_starve == 3, the ALU wins the next arbitration regardless of load; the counter then clears.
  - The counter also clears whenever the ALU wins.
  - Reset value 0.
- Undefined: strict load priority; the ALU can starve indefinitely under back-to-back loads.

Test Plan:
- Reset with alu_valid=1: alu_ready=0 and write_en=0 while rst_n=0; after release, alu_ready=1 and busy=0.
- ALU rd=5, data=0xDEADBEEF, handshake at edge k, issue_rd=5 two edges earlier → busy[5]=1; write_en=1, write_to=5, write_data=0xDEADBEEF for one cycle after edge k+1; busy[5]=0 after edge k+1.
- Both valid same edge, ld rd=3 / 0x11, alu rd=3 / 0x22 → write of 0x11 to r3, then 0x22 to r3 the next cycle; alu_ready=0 for the intervening cycle.
- ALU rd=0, data=0xFFFFFFFF → accepted, write_en stays 0 throughout; busy unchanged; issue_rd=0 never sets busy[0].
- Same edge: issue_valid with issue_rd=7 and drain of an entry with rd=7 → busy[7]=1 afterward.
- Loads valid every cycle and ALU valid continuously:
  - Without WB_FAIR_EN, no ALU write occurs over 20 cycles.
  - With WB_FAIR_EN, an ALU write occurs on every 4th write slot.
